// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder over GF(256), field poly 0x11D, generator roots alpha^0..alpha^15.
// Latency: an accepted message symbol appears on m_data one cycle later; parity follows the message.
// Backpressure: a stalled output register freezes outputs, the LFSR and the counter, and drops s_ready.
module rs_encoder #(
  parameter int N          = 255,
  parameter int K          = 239,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop
);

  localparam int TWO_T = N - K;
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] CNT_MSG_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_PAR_LAST = CW'(TWO_T - 1);

  // The GF arithmetic below is written for 8-bit symbols only.
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("rs_encoder: only DATA_WIDTH = 8 is supported");
  end
  if (N > 255 || K < 1 || TWO_T < 2) begin : g_bad_code
    $error("rs_encoder: need K >= 1, N - K >= 2 and N <= 255");
  end

  // Multiply by alpha (x) modulo 0x11D.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Shift-and-add GF(256) multiply; with one constant operand this folds to plain XOR logic.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Expand prod (x + alpha^i); returns g0..g(2T-1) packed with g0 in the low byte (g(2T) = 1 implied).
  function automatic logic [8*TWO_T-1:0] gen_poly();
    logic [7:0]         g [TWO_T+1];
    logic [7:0]         root;
    logic [8*TWO_T-1:0] res;
    for (int j = 0; j <= TWO_T; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < TWO_T; i++) begin
      for (int j = TWO_T; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_xtime(root);
    end
    for (int j = 0; j < TWO_T; j++) res[8*j +: 8] = g[j];
    return res;
  endfunction

  localparam logic [8*TWO_T-1:0] GEN = gen_poly();

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [TWO_T-1:0][7:0]        lfsr_q, lfsr_d;
  logic                         m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]        m_data_q, m_data_d;
  logic                         m_sop_q, m_sop_d;
  logic                         m_eop_q, m_eop_d;
  logic                         out_free;
  logic                         accept;
  logic [7:0]                   fb;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_MSG;
    else     state_q <= state_d;
  end

  // Next state: leave MSG on the last message accept, leave PAR when the last parity is loaded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MSG:  if (accept && cnt_q == CNT_MSG_LAST) state_d = ST_PAR;
      ST_PAR:  if (out_free && cnt_q == CNT_PAR_LAST) state_d = ST_MSG;
      default: state_d = ST_MSG;
    endcase
  end

  // Handshake outputs: input is only taken in MSG while the output register can be reloaded.
  always_comb begin
    out_free = !m_valid_q || m_ready;
    s_ready  = (state_q == ST_MSG) && out_free;
    accept   = s_valid && s_ready;
  end

  // Datapath next-state: forward and divide in MSG, shift the remainder out in PAR.
  always_comb begin
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sop_d   = m_sop_q;
    m_eop_d   = m_eop_q;
    fb        = 8'h00;
    if (state_q == ST_MSG && accept) begin
      fb        = s_data ^ lfsr_q[TWO_T-1];
      lfsr_d[0] = gf_mul(fb, GEN[7:0]);
      for (int i = 1; i < TWO_T; i++) begin
        lfsr_d[i] = lfsr_q[i-1] ^ gf_mul(fb, GEN[8*i +: 8]);
      end
      m_data_d  = s_data;
      m_valid_d = 1'b1;
      m_sop_d   = (cnt_q == '0);
      m_eop_d   = 1'b0;
      cnt_d     = (cnt_q == CNT_MSG_LAST) ? '0 : cnt_q + CW'(1);
    end else if (state_q == ST_PAR && out_free) begin
      // Shifting zeros in leaves the LFSR clear for the next codeword.
      lfsr_d    = {lfsr_q[TWO_T-2:0], 8'h00};
      m_data_d  = lfsr_q[TWO_T-1];
      m_valid_d = 1'b1;
      m_sop_d   = 1'b0;
      m_eop_d   = (cnt_q == CNT_PAR_LAST);
      cnt_d     = (cnt_q == CNT_PAR_LAST) ? '0 : cnt_q + CW'(1);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset abandons any partial codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      lfsr_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sop_q   <= m_sop_d;
      m_eop_q   <= m_eop_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sop   = m_sop_q;
  assign m_eop   = m_eop_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: log/antilog GF model, polynomial long division and syndrome evaluation.
// Drives random messages with random s_valid gaps and random m_ready, scoreboarding every transfer.
// Covers reset, known-answer parity, back-to-back throughput, stalls, mid-codeword reset, held eop.
module tb_rs_encoder;
  localparam int N  = 255;
  localparam int K  = 239;
  localparam int TT = N - K;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;

  always #5 clk = ~clk;

  rs_encoder #(.N(N), .K(K), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- GF(256) model via log/antilog tables ----------------
  logic [7:0] exp_t [255];
  int         log_t [256];
  logic [7:0] gpoly [TT+1];
  logic [7:0] msg_buf [K];
  logic [7:0] cw_buf  [N];
  logic [7:0] msgs [20][K];

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_model();
    int x;
    logic [7:0] nxt [TT+1];
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x[7:0];
      log_t[x] = i;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11D;
    end
    for (int j = 0; j <= TT; j++) gpoly[j] = 8'h00;
    gpoly[0] = 8'h01;
    // Polynomial product with each factor (x + alpha^i), as a convolution into a fresh array.
    for (int i = 0; i < TT; i++) begin
      for (int j = 0; j <= TT; j++) nxt[j] = mul(gpoly[j], exp_t[i]);
      for (int j = 1; j <= TT; j++) nxt[j] = nxt[j] ^ gpoly[j-1];
      for (int j = 0; j <= TT; j++) gpoly[j] = nxt[j];
    end
  endtask

  // Codeword = msg(x)*x^16 + (msg(x)*x^16 mod g(x)), by long division on a degree-indexed array.
  task automatic model_encode();
    logic [7:0] r [N];
    logic [7:0] c;
    for (int i = 0; i < K; i++) r[N-1-i] = msg_buf[i];
    for (int d = 0; d < TT; d++) r[d] = 8'h00;
    for (int d = N - 1; d >= TT; d--) begin
      c = r[d];
      for (int j = 0; j <= TT; j++) r[d-TT+j] = r[d-TT+j] ^ mul(c, gpoly[j]);
    end
    for (int i = 0; i < K; i++) cw_buf[i] = msg_buf[i];
    for (int p = 0; p < TT; p++) cw_buf[K+p] = r[TT-1-p];
  endtask

  // ---------------- Scoreboard / monitor ----------------
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] runa_q [$];
  bit   sb_en = 1'b1;
  int   idx = 0, acc = 0, srdy_low = 0;
  bit   par_flag = 1'b0, prev_stall = 1'b0, first_xfer_seen = 1'b0;
  logic [7:0] prev_data;
  logic prev_sop, prev_eop;
  int   acc_first_cyc = 0, sop_cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0;
  int   stall_eop_start = 0, stall_eop_end = 0;
  logic [7:0] e;

  always @(negedge clk) begin
    if (rst) begin
      idx = 0; acc = 0; par_flag = 1'b0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_sop", m_sop, prev_sop);
        chk("hold_eop", m_eop, prev_eop);
      end
      if (m_valid && !m_ready) chk("bp_s_ready", s_ready, 0);
      if (m_valid && m_eop && !prev_stall && !m_ready) stall_eop_start = cyc;
      if (m_valid && m_eop && m_ready && prev_stall) stall_eop_end = cyc;
      if (m_valid && m_eop) par_flag = 1'b0;
      if (par_flag) chk("s_ready_in_par", s_ready, 0);
      if (!s_ready) srdy_low++;
      if (m_valid && m_ready) begin
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %0h expected no output (cycle %0d)", m_data, cyc);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              errors++;
              $display("FAIL data[%0d]: got %0h expected %0h (cycle %0d)", idx, m_data, e, cyc);
            end
            chk("sop", m_sop, idx == 0);
            chk("eop", m_eop, idx == N - 1);
          end
        end
        got_q.push_back(m_data);
        if (!first_xfer_seen) begin first_xfer_cyc = cyc; first_xfer_seen = 1'b1; end
        last_xfer_cyc = cyc;
        if (idx == 0) sop_cyc = cyc;
        idx = (idx == N - 1) ? 0 : idx + 1;
      end
      if (s_valid && s_ready) begin
        if (acc == 0) acc_first_cyc = cyc;
        acc++;
        if (acc == K) begin acc = 0; par_flag = 1'b1; end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_sop   = m_sop;
      prev_eop   = m_eop;
    end
  end

  // ---------------- Downstream ready driver ----------------
  int ready_pct = 100;
  bit hold_eop  = 1'b0;
  int hold_cnt  = 0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_eop && m_valid && m_eop) begin
        hold_eop = 1'b0;
        hold_cnt = 10;
        m_ready  = 1'b0;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        m_ready = (hold_cnt == 0) ? ($urandom_range(99) < ready_pct) : 1'b0;
      end else begin
        m_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic finish_now(input string why);
    errors++;
    $display("FAIL %s: got timeout expected progress (cycle %0d)", why, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench stopped");
  endtask

  // Send the first nsym symbols of msg_buf; a complete message also queues its model codeword.
  task automatic send(input int nsym, input int gap_pct);
    int t;
    if (nsym == K) begin
      model_encode();
      for (int i = 0; i < N; i++) exp_q.push_back(cw_buf[i]);
    end
    for (int i = 0; i < nsym; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = msg_buf[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        t++;
        if (t > 2000) finish_now("send_accept");
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    finish_now("watchdog");
  end

  // ---------------- Main sequence ----------------
  initial begin
    int nz;
    logic [7:0] s;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    build_model();

    // Hand-computed anchors for the model itself.
    chk("alpha8", exp_t[8], 8'h1D);
    chk("g0_literal", gpoly[0], 8'h3B);
    chk("g15_literal", gpoly[15], 8'h3B);
    chk("g0_is_alpha120", gpoly[0], exp_t[120]);
    chk("g16_monic", gpoly[16], 8'h01);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_m_sop", m_sop, 0);
    chk("rst_m_eop", m_eop, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // 1: all-zero message.
    got_q.delete();
    srdy_low = 0;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    send(K, 0);
    drain("t1_drain");
    repeat (5) @(posedge clk);
    #1;
    chk("t1_s_ready_low", srdy_low, 16);
    chk("t1_count", got_q.size(), N);
    chk("t1_sop_latency", sop_cyc - acc_first_cyc, 1);

    // 2: single 1 in the lowest message position -> parity is g15..g0.
    got_q.delete();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    msg_buf[K-1] = 8'h01;
    send(K, 0);
    drain("t2_drain");
    chk("t2_count", got_q.size(), N);
    if (got_q.size() == N)
      for (int p = 0; p < TT; p++) chk("t2_parity_is_g", got_q[K+p], gpoly[TT-1-p]);

    // 3: 20 random back-to-back codewords at full rate.
    for (int m = 0; m < 20; m++)
      for (int i = 0; i < K; i++) msgs[m][i] = 8'($urandom);
    got_q.delete();
    first_xfer_seen = 1'b0;
    for (int m = 0; m < 20; m++) begin
      for (int i = 0; i < K; i++) msg_buf[i] = msgs[m][i];
      send(K, 0);
    end
    drain("t3_drain");
    chk("t3_count", got_q.size(), 20 * N);
    chk("t3_cycles", last_xfer_cyc - first_xfer_cyc + 1, 20 * N);
    if (got_q.size() == 20 * N) begin
      for (int m = 0; m < 20; m++) begin
        nz = 0;
        for (int i = 0; i < TT; i++) begin
          s = 8'h00;
          for (int k = 0; k < N; k++) s = mul(s, exp_t[i]) ^ got_q[m*N+k];
          if (s != 8'h00) nz++;
        end
        chk("t3_syndromes_zero", nz, 0);
      end
    end
    runa_q = got_q;

    // 4: same messages with random backpressure and input gaps.
    got_q.delete();
    ready_pct = 50;
    for (int m = 0; m < 20; m++) begin
      for (int i = 0; i < K; i++) msg_buf[i] = msgs[m][i];
      send(K, 30);
    end
    drain("t4_drain");
    ready_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_count", got_q.size(), runa_q.size());
    nz = 0;
    if (got_q.size() == runa_q.size())
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== runa_q[i]) nz++;
    chk("t4_same_as_unstalled", nz, 0);

    // 5: reset after 100 accepted symbols, then an all-0xFF message.
    sb_en = 1'b0;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    send(100, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_m_valid_after_rst", m_valid, 0);
    exp_q.delete();
    got_q.delete();
    sb_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'hFF;
    send(K, 0);
    drain("t5_drain");
    chk("t5_count", got_q.size(), N);

    // 6: last parity held for 10 cycles with the next message already waiting.
    stall_eop_start = 0;
    stall_eop_end   = 0;
    hold_eop        = 1'b1;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    send(K, 0);
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    send(K, 0);
    drain("t6_drain");
    chk("t6_eop_hold_len", stall_eop_end - stall_eop_start, 10);
    chk("t6_accept_after_eop", acc_first_cyc >= stall_eop_end, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
